// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer and its digit cells.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_e;

  localparam logic [3:0]  BCD_MAX_DIGIT   = 4'd9;
  localparam logic [3:0]  SEC_TENS_RELOAD = 4'd5;
  localparam logic [3:0]  QUICK_ADD_TENS  = 4'd3;
  localparam int unsigned MIN_DIGITS_MAX  = 3;

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown chain: parallel load, or decrement on borrow_in
// with reload to RELOAD when passing through zero.
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter logic [3:0] RELOAD = BCD_MAX_DIGIT
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out,
  output logic       digit_zero
);

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (borrow_in) begin
      digit_d = digit_zero ? RELOAD : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign digit_zero = (digit_q == '0);
  assign borrow_out = borrow_in & digit_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Minutes:seconds BCD countdown timer with keypad entry and run/pause/cancel control.
// Define QUICK_ADD_EN to enable the +30 s quick_add strobe.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned MIN_DIGITS = 1
) (
  input  logic                    clock,
  input  logic                    clr,
  input  logic                    tick,
  input  logic                    key_valid,
  input  logic [3:0]              key_data,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    cancel,
  input  logic                    quick_add,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    zero,
  output logic                    running,
  output logic                    done
);

  localparam int unsigned NDIG = MIN_DIGITS + 2;
  localparam int unsigned W    = 4 * NDIG;

  if (MIN_DIGITS < 1 || MIN_DIGITS > MIN_DIGITS_MAX) begin : g_bad_min_digits
    $error("MIN_DIGITS must be in 1..%0d", MIN_DIGITS_MAX);
  end

  state_e          state_q, state_d;
  logic [W-1:0]    val, load_val, qa_sum;
  logic [NDIG-1:0] dz;
  logic [NDIG:0]   borrow;
  logic            load, dec, qa;
  logic            act_cancel, act_start, act_pause, act_qa, act_key, act_tick;
  logic            unused_underflow;

  // Digit 0 = seconds units, 1 = seconds tens, 2.. = minutes (LSD first).
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_digit_down #(
      .RELOAD((i == 1) ? SEC_TENS_RELOAD : BCD_MAX_DIGIT)
    ) u_digit (
      .clock     (clock),
      .clr       (clr),
      .load      (load),
      .load_val  (load_val[4*i +: 4]),
      .borrow_in (borrow[i]),
      .digit     (val[4*i +: 4]),
      .borrow_out(borrow[i+1]),
      .digit_zero(dz[i])
    );
  end

  assign borrow[0]        = dec;
  assign unused_underflow = borrow[NDIG];
  assign zero             = &dz;

`ifdef QUICK_ADD_EN
  logic [3:0] qa_tens;
  logic       qa_carry;

  assign qa = quick_add;

  always_comb begin
    qa_sum   = val;
    qa_tens  = val[7:4] + QUICK_ADD_TENS;
    qa_carry = (qa_tens > SEC_TENS_RELOAD);
    qa_sum[7:4] = qa_carry ? (qa_tens - (SEC_TENS_RELOAD + 4'd1)) : qa_tens;
    for (int unsigned i = 2; i < NDIG; i++) begin
      if (qa_carry) begin
        if (val[4*i +: 4] >= BCD_MAX_DIGIT) begin
          qa_sum[4*i +: 4] = '0;
        end else begin
          qa_sum[4*i +: 4] = val[4*i +: 4] + 4'd1;
          qa_carry         = 1'b0;
        end
      end
    end
    if (qa_carry) begin
      qa_sum = {{MIN_DIGITS{BCD_MAX_DIGIT}}, SEC_TENS_RELOAD, BCD_MAX_DIGIT};
    end
  end
`else
  logic unused_quick_add;

  assign qa               = 1'b0;
  assign qa_sum           = '0;
  assign unused_quick_add = quick_add;
`endif

  // Only the highest-priority strobe present acts in a given cycle; DONE ignores all.
  always_comb begin
    act_cancel = 1'b0;
    act_start  = 1'b0;
    act_pause  = 1'b0;
    act_qa     = 1'b0;
    act_key    = 1'b0;
    act_tick   = 1'b0;
    if (state_q != DONE) begin
      act_cancel = cancel;
      act_start  = start & ~cancel;
      act_pause  = pause & ~cancel & ~start;
      act_qa     = qa & ~cancel & ~start & ~pause;
      act_key    = key_valid & ~cancel & ~start & ~pause & ~qa;
      act_tick   = tick & ~cancel & ~start & ~pause & ~qa & ~key_valid;
    end
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (act_start && !zero) begin
          state_d = RUN;
        end else if (act_qa && zero) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (act_cancel) begin
          state_d = IDLE;
        end else if (act_pause) begin
          state_d = PAUSED;
        end else if (dec && val == W'(1)) begin
          state_d = DONE;
        end
      end
      PAUSED: begin
        if (act_cancel) begin
          state_d = IDLE;
        end else if (act_start) begin
          state_d = RUN;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  // From zero, the +30 s sum is exactly 0:30, so one path serves both quick_add cases.
  always_comb begin
    load     = 1'b0;
    load_val = val;
    dec      = 1'b0;
    if (act_cancel) begin
      load     = 1'b1;
      load_val = '0;
    end else if (act_qa) begin
      load     = 1'b1;
      load_val = qa_sum;
    end else if (act_key && state_q == IDLE && key_data <= BCD_MAX_DIGIT) begin
      load     = 1'b1;
      load_val = {val[W-5:0], key_data};
    end else if (act_tick && state_q == RUN && !zero) begin
      dec = 1'b1;
    end
  end

  always_comb begin
    running = (state_q == RUN);
    done    = (state_q == DONE);
  end

  assign sec_ones = val[3:0];
  assign sec_tens = val[7:4];
  assign mins     = val[W-1:8];

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: MIN_DIGITS=1 and MIN_DIGITS=2 instances share stimulus
// and are checked every cycle against a minutes/seconds arithmetic model.
module tb_bcd_countdown_timer;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSED = 2, ST_DONE = 3;
`ifdef QUICK_ADD_EN
  localparam bit QA = 1'b1;
`else
  localparam bit QA = 1'b0;
`endif

  logic       clock = 1'b0, clr = 1'b0, tick = 1'b0, key_valid = 1'b0;
  logic [3:0] key_data = 4'd0;
  logic       start = 1'b0, pause = 1'b0, cancel = 1'b0, quick_add = 1'b0;

  logic [3:0] so0, st0, mn0, so1, st1;
  logic [7:0] mn1;
  logic       z0, r0, d0, z1, r1, d1;

  int  errors = 0, checks = 0;
  bit  cmp_en = 1'b0;
  int  m_st[2], m_M[2], m_S[2];

  always #5 clock = ~clock;

  bcd_countdown_timer #(.MIN_DIGITS(1)) u_dut_md1 (
    .clock(clock), .clr(clr), .tick(tick), .key_valid(key_valid), .key_data(key_data),
    .start(start), .pause(pause), .cancel(cancel), .quick_add(quick_add),
    .sec_ones(so0), .sec_tens(st0), .mins(mn0), .zero(z0), .running(r0), .done(d0)
  );

  bcd_countdown_timer #(.MIN_DIGITS(2)) u_dut_md2 (
    .clock(clock), .clr(clr), .tick(tick), .key_valid(key_valid), .key_data(key_data),
    .start(start), .pause(pause), .cancel(cancel), .quick_add(quick_add),
    .sec_ones(so1), .sec_tens(st1), .mins(mn1), .zero(z1), .running(r1), .done(d1)
  );

  // Expected outputs packed as {done, running, zero, mins BCD, sec_tens, sec_ones}.
  function automatic int pack(int nd, bit d, bit r, int m, int s);
    int v = 0;
    int p = 1;
    for (int i = 0; i < nd; i++) begin
      v = v | (((m / p) % 10) << (4*i + 8));
      p = p * 10;
    end
    v = v | ((s / 10) << 4) | (s % 10);
    v = v | (int'(m == 0 && s == 0) << (4*nd + 8));
    v = v | (int'(r) << (4*nd + 9)) | (int'(d) << (4*nd + 10));
    return v;
  endfunction

  function automatic int actv(int k);
    if (k == 0) return int'({17'b0, d0, r0, z0, mn0, st0, so0});
    return int'({13'b0, d1, r1, z1, mn1, st1, so1});
  endfunction

  function automatic int modelv(int k);
    return pack(k + 1, m_st[k] == ST_DONE, m_st[k] == ST_RUN, m_M[k], m_S[k]);
  endfunction

  task automatic model_step(input int k);
    int maxm = (k == 0) ? 9 : 99;
    int pw   = (k == 0) ? 1000 : 10000;
    bit z    = (m_M[k] == 0 && m_S[k] == 0);
    int v;
    if (m_st[k] == ST_DONE) begin
      m_st[k] = ST_IDLE;
    end else if (cancel) begin
      m_M[k] = 0; m_S[k] = 0; m_st[k] = ST_IDLE;
    end else if (start) begin
      if ((m_st[k] == ST_IDLE && !z) || m_st[k] == ST_PAUSED) m_st[k] = ST_RUN;
    end else if (pause) begin
      if (m_st[k] == ST_RUN) m_st[k] = ST_PAUSED;
    end else if (QA && quick_add) begin
      if (m_st[k] == ST_IDLE && z) m_st[k] = ST_RUN;
      m_S[k] = m_S[k] + 30;
      if (m_S[k] >= 60) begin
        m_S[k] = m_S[k] - 60;
        m_M[k] = m_M[k] + 1;
        if (m_M[k] > maxm) begin
          m_M[k] = maxm; m_S[k] = 59;
        end
      end
    end else if (key_valid) begin
      if (m_st[k] == ST_IDLE && key_data <= 4'd9) begin
        v = ((m_M[k] * 100 + m_S[k]) * 10 + int'(key_data)) % pw;
        m_M[k] = v / 100;
        m_S[k] = v % 100;
      end
    end else if (tick) begin
      if (m_st[k] == ST_RUN && !z) begin
        if (m_S[k] > 0) m_S[k] = m_S[k] - 1;
        else begin
          m_M[k] = m_M[k] - 1; m_S[k] = 59;
        end
        if (m_M[k] == 0 && m_S[k] == 0) m_st[k] = ST_DONE;
      end
    end
  endtask

  always @(posedge clock or posedge clr) begin
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        m_st[k] = ST_IDLE; m_M[k] = 0; m_S[k] = 0;
      end else begin
        model_step(k);
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (actv(k) != modelv(k)) begin
          errors++;
          $display("FAIL cycle_cmp md=%0d t=%0t got=%h exp=%h", k + 1, $time, actv(k), modelv(k));
        end
      end
    end
  end

  // Literal expectation checked against both the DUT and the model.
  task automatic pin(input string name, input int k, input bit d, input bit r, input int m, input int s);
    int exp = pack(k + 1, d, r, m, s);
    checks++;
    if (actv(k) != exp) begin
      errors++;
      $display("FAIL %s dut md=%0d got=%h exp=%h", name, k + 1, actv(k), exp);
    end
    checks++;
    if (modelv(k) != exp) begin
      errors++;
      $display("FAIL %s model md=%0d got=%h exp=%h", name, k + 1, modelv(k), exp);
    end
  endtask

  task automatic step(input bit t, input bit kv, input logic [3:0] kd,
                      input bit s, input bit p, input bit c, input bit q);
    tick = t; key_valid = kv; key_data = kd; start = s; pause = p; cancel = c; quick_add = q;
    @(posedge clock); #1;
    tick = 0; key_valid = 0; key_data = 4'd0; start = 0; pause = 0; cancel = 0; quick_add = 0;
  endtask

  task automatic key(input logic [3:0] d);   step(0, 1, d, 0, 0, 0, 0); endtask
  task automatic do_start();                 step(0, 0, 4'd0, 1, 0, 0, 0); endtask
  task automatic do_cancel();                step(0, 0, 4'd0, 0, 0, 1, 0); endtask
  task automatic do_qa();                    step(0, 0, 4'd0, 0, 0, 0, 1); endtask
  task automatic ticks(input int n);
    repeat (n) step(1, 0, 4'd0, 0, 0, 0, 0);
  endtask

  initial begin
    #1 clr = 1'b1;
    #1 cmp_en = 1'b1;
    @(posedge clock); #1 clr = 1'b0;
    pin("reset", 0, 0, 0, 0, 0);
    pin("reset", 1, 0, 0, 0, 0);

    key(4'd1); key(4'd3); key(4'd0); do_start(); ticks(3);
    pin("entry_1_30_run3", 0, 0, 1, 1, 27);
    pin("entry_1_30_run3", 1, 0, 1, 1, 27);

    do_cancel(); key(4'd0); key(4'd2); do_start(); ticks(1);
    pin("at_0_01", 0, 0, 1, 0, 1);
    ticks(1);
    pin("done_pulse", 0, 1, 0, 0, 0);
    pin("done_pulse", 1, 1, 0, 0, 0);
    step(0, 0, 4'd0, 0, 0, 0, 0);
    pin("after_done", 0, 0, 0, 0, 0);

    do_cancel(); key(4'd1); key(4'd0); key(4'd0); do_start(); ticks(1);
    pin("tens_reload", 0, 0, 1, 0, 59);
    do_cancel(); key(4'd9); key(4'd9); do_start(); ticks(10);
    pin("entry_99", 0, 0, 1, 0, 89);

    do_cancel(); key(4'd2); key(4'd1); key(4'd5); do_start();
    step(1, 0, 4'd0, 0, 1, 0, 0);
    ticks(5);
    pin("paused_hold", 0, 0, 0, 2, 15);
    do_start();
    pin("resumed", 0, 0, 1, 2, 15);
    ticks(1);
    pin("resumed_tick", 0, 0, 1, 2, 14);

    do_cancel();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    pin("shift_discard", 0, 0, 0, 3, 45);
    pin("shift_discard", 1, 0, 0, 23, 45);
    do_start(); ticks(1);
    pin("md2_tick", 1, 0, 1, 23, 44);
    do_cancel();
    pin("cancel_run", 1, 0, 0, 0, 0);

    key(4'd4); key(4'd2); do_start(); ticks(1);
    clr = 1'b1; #2;
    pin("clr_mid_run", 0, 0, 0, 0, 0);
    pin("clr_mid_run", 1, 0, 0, 0, 0);
    @(posedge clock); #1 clr = 1'b0;

`ifdef QUICK_ADD_EN
    do_qa();
    pin("qa_from_zero", 0, 0, 1, 0, 30);
    do_cancel(); key(4'd4); key(4'd5); do_qa();
    pin("qa_0_45", 0, 0, 0, 1, 15);
    do_cancel(); key(4'd9); key(4'd5); key(4'd0); do_qa();
    pin("qa_saturate", 0, 0, 0, 9, 59);
    pin("qa_md2_9_50", 1, 0, 0, 10, 20);
`else
    do_qa();
    pin("qa_ignored", 0, 0, 0, 0, 0);
`endif
    do_cancel();

    for (int n = 0; n < 4000; n++) begin
      tick      = ($urandom_range(0, 2) == 0);
      key_valid = ($urandom_range(0, 4) == 0);
      key_data  = 4'($urandom_range(0, 15));
      start     = ($urandom_range(0, 9) == 0);
      pause     = ($urandom_range(0, 24) == 0);
      cancel    = ($urandom_range(0, 79) == 0);
      quick_add = ($urandom_range(0, 29) == 0);
      clr       = ($urandom_range(0, 499) == 0);
      @(posedge clock); #1;
    end
    tick = 0; key_valid = 0; start = 0; pause = 0; cancel = 0; quick_add = 0; clr = 0;
    @(posedge clock); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
